// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
// One shared adder/subtractor is reused for WIDTH iterations. Multiply uses shift-add and
// divide uses restoring division. Signed operations run on magnitudes and fix the sign at the end.
// The latency is the same for every op and operand: start sampled in cycle 0 gives done in cycle 35.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset; abandons any operation and clears hi/lo
//   start_i        one-cycle request, accepted only while idle
//   op_i           00=MULTU 01=MULT 10=DIVU 11=DIV (op_i[1]=divide, op_i[0]=signed)
//   a_i, b_i       multiplicand/dividend and multiplier/divisor, sampled with start_i
//   busy_o         high while an operation is in flight
//   done_o         one-cycle pulse; hi_o/lo_o are valid from this cycle
//   hi_o, lo_o     product[63:32]/[31:0], or remainder/quotient
//   div_by_zero_o  pulses with done_o when a divide had a zero divisor
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StPrep, StRun, StFix} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] acc_hi_q;   // multiply: upper product half; divide: remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiply: lower product half; divide: quotient
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic             no_borrow;
    logic [WIDTH-1:0] div_hi_d;
    logic [WIDTH-1:0] div_lo_d;
    logic             dbz;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign is_div = op_q[1];
    assign dbz    = is_div && (b_q == '0);

    always_comb begin
        mag_a = a_q;
        mag_b = b_q;
        if (op_q[0] && a_q[WIDTH-1]) mag_a = -a_q;
        if (op_q[0] && b_q[WIDTH-1]) mag_b = -b_q;
    end

    // Shared adder: multiply adds |b| to the upper half, divide subtracts |b| from the
    // left-shifted remainder (SUB=1 as invert plus carry-in).
    always_comb begin
        add_x   = is_div ? {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]} : acc_hi_q;
        add_y   = is_div ? ~mag_b_q : mag_b_q;
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, is_div};
    end

    always_comb begin
        // Carry-out is kept and shifted back into the top of the upper half.
        mul_sum  = acc_lo_q[0] ? add_sum : {1'b0, acc_hi_q};
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        // The shifted-out remainder MSB is a 33rd bit; when set the trial always succeeds.
        no_borrow = add_sum[WIDTH] | acc_hi_q[WIDTH-1];
        div_hi_d  = no_borrow ? add_sum[WIDTH-1:0] : add_x;
        div_lo_d  = {acc_lo_q[WIDTH-2:0], no_borrow};
    end

    always_comb begin
        prod   = {acc_hi_q, acc_lo_q};
        fix_hi = acc_hi_q;
        fix_lo = acc_lo_q;
        if (is_div) begin
            if (dbz) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                if (neg_quo_q) fix_lo = -acc_lo_q;
                if (neg_rem_q) fix_hi = -acc_hi_q;
            end
        end else if (neg_quo_q) begin
            prod   = -{acc_hi_q, acc_lo_q};
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mag_b_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        busy_q  <= 1'b1;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    mag_b_q   <= mag_b;
                    acc_hi_q  <= '0;
                    acc_lo_q  <= mag_a;
                    neg_quo_q <= op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_q <= op_q[0] & a_q[WIDTH-1];
                    cnt_q     <= '0;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (is_div) begin
                        acc_hi_q <= div_hi_d;
                        acc_lo_q <= div_lo_d;
                    end else begin
                        acc_hi_q <= mul_hi_d;
                        acc_lo_q <= mul_lo_d;
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    dbz_q   <= dbz;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer plus a short randomized run against a native-arithmetic model.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    int vectors = 0;
    int miscompares = 0;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .busy_o        (busy),
        .done_o        (done),
        .hi_o          (hi),
        .lo_o          (lo),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one op and wait for done; lat counts negedges after the sampling edge (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        lat = -1; rhi = 'x; rlo = 'x; rdbz = 1'bx; busy_ok = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n; rhi = hi; rlo = lo; rdbz = dbz;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (dbz !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", dbz); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int lat; logic [31:0] rh, rl; logic rd, bok;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rh, rl, rd, bok);
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL multu_latency got %0d want 35", lat); end
        vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL multu_busy got %b want 1", bok); end
        vectors++; if (rh !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", rh); end
        vectors++; if (rl !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", rl); end
        vectors++; if (rd !== 1'b0) begin miscompares++; $display("FAIL multu_dbz got %b want 0", rd); end
    endtask

    task automatic test_mult();
        int lat; logic [31:0] rh, rl; logic rd, bok;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, rh, rl, rd, bok);
        vectors++; if (rh !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_neg_hi got %h want ffffffff", rh); end
        vectors++; if (rl !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_neg_lo got %h want ffffffeb", rl); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, rh, rl, rd, bok);
        vectors++; if (rh !== 32'h4000_0000) begin miscompares++; $display("FAIL mult_min_hi got %h want 40000000", rh); end
        vectors++; if (rl !== 32'h0) begin miscompares++; $display("FAIL mult_min_lo got %h want 0", rl); end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL mult_latency got %0d want 35", lat); end
    endtask

    task automatic test_div();
        int lat; logic [31:0] rh, rl; logic rd, bok;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, rh, rl, rd, bok);
        vectors++; if (rl !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_lo got %h want fffffffd", rl); end
        vectors++; if (rh !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_hi got %h want ffffffff", rh); end
        run_op(2'b10, 32'd100, 32'd7, lat, rh, rl, rd, bok);
        vectors++; if (rl !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %h want 0000000e", rl); end
        vectors++; if (rh !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %h want 00000002", rh); end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL divu_latency got %0d want 35", lat); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] rh, rl; logic rd, bok;
        run_op(2'b10, 32'd100, 32'd0, lat, rh, rl, rd, bok);
        vectors++; if (rl !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu0_lo got %h want ffffffff", rl); end
        vectors++; if (rh !== 32'd100) begin miscompares++; $display("FAIL divu0_hi got %h want 00000064", rh); end
        vectors++; if (rd !== 1'b1) begin miscompares++; $display("FAIL divu0_dbz got %b want 1", rd); end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL divu0_latency got %0d want 35", lat); end
        @(negedge clk);
        vectors++; if (dbz !== 1'b0) begin miscompares++; $display("FAIL divu0_dbz_pulse got %b want 0", dbz); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL divu0_done_pulse got %b want 0", done); end
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, lat, rh, rl, rd, bok);
        vectors++; if (rh !== 32'hFFFF_FFFB) begin miscompares++; $display("FAIL div0_hi got %h want fffffffb", rh); end
        vectors++; if (rl !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo got %h want ffffffff", rl); end
        vectors++; if (rd !== 1'b1) begin miscompares++; $display("FAIL div0_dbz got %b want 1", rd); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, rd, bok);
        vectors++; if (rl !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_lo got %h want 80000000", rl); end
        vectors++; if (rh !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi got %h want 0", rh); end
        vectors++; if (rd !== 1'b0) begin miscompares++; $display("FAIL div_ovf_dbz got %b want 0", rd); end
    endtask

    task automatic test_start_busy();
        int lat = -1;
        int extra = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin op = 2'b10; a = 32'd1000; b = 32'd3; end
            if (done) begin lat = n; break; end
        end
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL busy_start_latency got %0d want 35", lat); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL busy_start_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL busy_start_lo got %h want 0000002a", lo); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL busy_start_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat1 = -1;
        int lat2 = -1;
        logic [31:0] lo_mid = 'x;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat1 = n; break; end
        end
        vectors++; if (lo !== 32'd15) begin miscompares++; $display("FAIL b2b_first_lo got %h want 0000000f", lo); end
        // Request the next op in the done cycle itself.
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 10) lo_mid = lo;
            if (done) begin lat2 = n; break; end
        end
        vectors++; if (lat1 !== 35) begin miscompares++; $display("FAIL b2b_lat1 got %0d want 35", lat1); end
        vectors++; if (lat2 !== 35) begin miscompares++; $display("FAIL b2b_lat2 got %0d want 35", lat2); end
        vectors++; if (lo_mid !== 32'd15) begin miscompares++; $display("FAIL b2b_hold_lo got %h want 0000000f", lo_mid); end
        vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL b2b_second_lo got %h want 0000000e", lo); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL b2b_second_hi got %h want 00000002", hi); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL rst_mid_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL rst_mid_lo got %h want 0", lo); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rst_mid_done got %0d want 0", dones); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rh, rl; logic rd, bok;
        logic [1:0] o;
        logic [31:0] va, vb, eh, el;
        logic ed;
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        for (int i = 0; i < 200; i++) begin
            o  = 2'($urandom_range(0, 3));
            va = $urandom();
            vb = $urandom();
            case ($urandom_range(0, 7))
                0: vb = 32'd0;
                1: vb = 32'($urandom_range(1, 20));
                2: va = 32'($urandom_range(0, 1000));
                3: vb = 32'hFFFF_FFFF;
                default: ;
            endcase
            sa = 64'(signed'(va));
            sb = 64'(signed'(vb));
            ed = 1'b0;
            case (o)
                2'b00: begin up = {32'h0, va} * {32'h0, vb}; eh = up[63:32]; el = up[31:0]; end
                2'b01: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
                2'b10: begin
                    if (vb == 0) begin el = 32'hFFFF_FFFF; eh = va; ed = 1'b1; end
                    else begin el = va / vb; eh = va % vb; end
                end
                default: begin
                    if (vb == 0) begin el = 32'hFFFF_FFFF; eh = va; ed = 1'b1; end
                    else begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
                end
            endcase
            run_op(o, va, vb, lat, rh, rl, rd, bok);
            vectors++;
            if (rh !== eh || rl !== el || rd !== ed || lat !== 35) begin
                miscompares++;
                $display("FAIL random op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=35",
                         o, va, vb, rh, rl, rd, lat, eh, el, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
